demux3_route: RTL and testbench
===============================

// Module: demux3_route
// PURPOSE
//  Registered 1-to-3 demultiplexer that routes one WIDTH-bit value to one of three
//  destinations, or broadcasts it to all three. This is the inverse of the datapath's
//  3:1 select mux. Used on the CPU write-back/result path where a producer hands off
//  a value and each consumer may stall independently. Uses valid/ready on the input
//  and on every output, with a single holding register.
// PARAMETERS
//  WIDTH  16  data width of the input and all outputs
// PORTS
//  clk        in   1      clock, rising edge
//  rst_n      in   1      asynchronous active-low reset
//  in_data    in   WIDTH  value to route
//  in_sel     in   2      route select: 00->out1, 01->out2, 10->out3, 11->broadcast
//  in_valid   in   1      producer offers in_data/in_sel
//  in_ready   out  1      block can accept this cycle
//  out1_data  out  WIDTH  held value (out2_data, out3_data are identical copies)
//  out2_data  out  WIDTH
//  out3_data  out  WIDTH
//  out1_valid out  1      destination 1 has a pending value (likewise out2/out3)
//  out2_valid out  1
//  out3_valid out  1
//  out1_ready in   1      destination 1 consumes when valid&ready (likewise out2/out3)
//  out2_ready in   1
//  out3_ready in   1
//  xfer_count out  16     only with DEMUX_STATS_EN: count of completed input transfers
// BEHAVIOUR
//  - Reset (rst_n low, asynchronous): data_q=0, pending[2:0]=0, state=IDLE.
//    All outK_valid=0, all outK_data=0, xfer_count=0. No transfer while rst_n is low.
//  - States:
//    - IDLE (pending==0).
//    - BUSY (pending!=0).
//  - Input accept: in_valid & in_ready at a rising edge.
//    - data_q<=in_data.
//    - pending<=onehot(in_sel): 001, 010 or 100. For in_sel=11, pending<=111.
//  - Outputs:
//    - outK_valid = pending[K], registered.
//    - Latency is 1 cycle: valid rises on the edge after acceptance.
//  - Drain: on outK_valid & outK_ready, pending[K] clears at that edge.
//    - Destinations drain independently and in any order.
//    - Broadcast completes when all three have consumed.
//  - in_ready = (pending & ~{out3_ready,out2_ready,out1_ready}) == 0.
//    - That is: IDLE, or every remaining pending bit is consumed this cycle.
//    - Back-to-back acceptance on the final-drain cycle is allowed. The new pending
//      value overrides the clear, and state stays BUSY. Full throughput is 1/cycle.
//    - in_ready is combinational from outK_ready. No path from in_valid to in_ready.
//  - While BUSY and not fully draining: in_ready=0. data_q and pending are held.
//  - outK_ready while outK_valid=0 has no effect.
//  - The producer must hold in_data/in_sel stable while in_valid & !in_ready.
//    The block does not check this.
//  - outK_data always equals data_q; consumers qualify it with outK_valid.
//  - Reset mid-operation: pending values are discarded and no output valid survives.
// CONFIGURATION
//  - DEMUX_STATS_EN defined:
//    - xfer_count port exists.
//    - It increments by 1 on each input accept, wraps 16'hFFFF->0, and resets to 0.
//  - Not defined: the port and counter are absent. Routing behaviour is identical.
// TESTING
//  1. Reset, all readies=1; in_data=16'h0001, sel=00, valid 1 cycle
//     -> next cycle out1_valid=1, out1_data=1, out2/3_valid=0; IDLE after 1 more cycle.
//  2. sel=01, data=16'h0002, out2_ready=0 for 3 cycles
//     -> out2_valid held 3 cycles, in_ready=0 throughout; drains on 4th, in_ready=1.
//  3. sel=11, data=16'h0004; out1 ready cyc1, out3 cyc2, out2 cyc4
//     -> valids drop individually; in_ready rises only in the out2 accept cycle.
//  4. Continuous in_valid, all readies=1, sel cycling 00,01,10,11
//     -> one accept per cycle, no bubbles, each value on the correct output(s).
//  5. Broadcast pending with out2 stalled, pulse rst_n low mid-cycle
//     -> all valids 0 immediately, in_ready=1, data=0.
//  6. DEMUX_STATS_EN: 65537 accepts -> xfer_count=1 (wrap); without macro, port absent.

Source files
------------

// File: rtl/demux3_route_if.sv
// Handshake bundle for demux3_route: one valid/ready input channel, three valid/ready outputs.
interface demux3_route_if #(
  parameter int unsigned WIDTH = 16
);
  logic [WIDTH-1:0] in_data;
  logic [1:0]       in_sel;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out1_data;
  logic [WIDTH-1:0] out2_data;
  logic [WIDTH-1:0] out3_data;
  logic             out1_valid;
  logic             out2_valid;
  logic             out3_valid;
  logic             out1_ready;
  logic             out2_ready;
  logic             out3_ready;

  modport slave (
    input  in_data, in_sel, in_valid, out1_ready, out2_ready, out3_ready,
    output in_ready, out1_data, out2_data, out3_data, out1_valid, out2_valid, out3_valid
  );

  modport master (
    output in_data, in_sel, in_valid, out1_ready, out2_ready, out3_ready,
    input  in_ready, out1_data, out2_data, out3_data, out1_valid, out2_valid, out3_valid
  );
endinterface

// File: rtl/demux3_route.sv
// Registered 1-to-3 demux / broadcaster with per-destination valid/ready and one holding register.
// Optional DEMUX_STATS_EN adds a 16-bit wrapping count of accepted input transfers.
module demux3_route #(
  parameter int unsigned WIDTH = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  demux3_route_if.slave     bus
`ifdef DEMUX_STATS_EN
  ,
  output logic [15:0]       xfer_count
`endif
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_data;
  logic [2:0]       r_pending;
  logic [2:0]       w_out_ready;
  logic [2:0]       w_remain;
  logic [2:0]       w_sel_onehot;
  logic             w_in_ready;
  logic             w_accept;

  assign w_out_ready = {bus.out3_ready, bus.out2_ready, bus.out1_ready};
  // Bits still pending after this edge if nothing new is accepted.
  assign w_remain    = r_pending & ~w_out_ready;
  assign w_in_ready  = (r_state == IDLE) || (w_remain == '0);
  assign w_accept    = bus.in_valid & w_in_ready;

  always_comb begin
    w_sel_onehot = '0;
    unique case (bus.in_sel)
      2'b00:   w_sel_onehot = 3'b001;
      2'b01:   w_sel_onehot = 3'b010;
      2'b10:   w_sel_onehot = 3'b100;
      default: w_sel_onehot = 3'b111;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_data    <= '0;
      r_pending <= '0;
    end else if (w_accept) begin
      // A new accept on the final-drain cycle overrides the clears.
      r_state   <= BUSY;
      r_data    <= bus.in_data;
      r_pending <= w_sel_onehot;
    end else begin
      r_pending <= w_remain;
      r_state   <= (w_remain == '0) ? IDLE : BUSY;
    end
  end

`ifdef DEMUX_STATS_EN
  logic [15:0] r_xfer_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_xfer_count <= '0;
    end else if (w_accept) begin
      r_xfer_count <= r_xfer_count + 16'd1;
    end
  end

  assign xfer_count = r_xfer_count;
`endif

  assign bus.in_ready   = w_in_ready;
  assign bus.out1_data  = r_data;
  assign bus.out2_data  = r_data;
  assign bus.out3_data  = r_data;
  assign bus.out1_valid = r_pending[0];
  assign bus.out2_valid = r_pending[1];
  assign bus.out3_valid = r_pending[2];

endmodule

// File: tb/tb_demux3_route.sv
// Scoreboard bench for demux3_route: driver pushes expected values per destination,
// a negedge monitor pops and compares on every valid&ready consumption.
module tb_demux3_route;

  logic clk;
  logic rst_n;
  int unsigned cycle;
  int pass_cnt;
  int total_cnt;

  logic [15:0] q1[$];
  logic [15:0] q2[$];
  logic [15:0] q3[$];

  demux3_route_if #(.WIDTH(16)) bus ();

`ifdef DEMUX_STATS_EN
  logic [15:0] xfer_count;
  demux3_route #(.WIDTH(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus), .xfer_count(xfer_count));
`else
  demux3_route #(.WIDTH(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h required %h", name, act, exp);
  endtask

  task automatic set_ready(input logic [2:0] r);
    bus.out1_ready = r[0];
    bus.out2_ready = r[1];
    bus.out3_ready = r[2];
  endtask

  // Model of routing: which destination queues get the value.
  task automatic push_exp(input logic [15:0] d, input logic [1:0] s);
    if (s == 2'b00 || s == 2'b11) q1.push_back(d);
    if (s == 2'b01 || s == 2'b11) q2.push_back(d);
    if (s == 2'b10 || s == 2'b11) q3.push_back(d);
  endtask

  // Offer one value; returns #1 after the accepting edge with in_valid dropped.
  task automatic send(input logic [15:0] d, input logic [1:0] s);
    bit done;
    done = 1'b0;
    bus.in_data  = d;
    bus.in_sel   = s;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        push_exp(d, s);
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    if (!done) chk("send_timeout", 32'd0, 32'd1);
  endtask

  // Monitor: compare consumed data against scoreboard queues.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.out1_valid && bus.out1_ready) begin
        if (q1.size() == 0) chk("out1_unexpected", 32'd1, 32'd0);
        else chk("out1_data", {16'd0, bus.out1_data}, {16'd0, q1.pop_front()});
      end
      if (bus.out2_valid && bus.out2_ready) begin
        if (q2.size() == 0) chk("out2_unexpected", 32'd1, 32'd0);
        else chk("out2_data", {16'd0, bus.out2_data}, {16'd0, q2.pop_front()});
      end
      if (bus.out3_valid && bus.out3_ready) begin
        if (q3.size() == 0) chk("out3_unexpected", 32'd1, 32'd0);
        else chk("out3_data", {16'd0, bus.out3_data}, {16'd0, q3.pop_front()});
      end
    end
  end

  initial begin
    int unsigned c0;
    cycle = 0;
    pass_cnt = 0;
    total_cnt = 0;
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.in_sel = '0;
    set_ready(3'b111);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valids", {29'd0, bus.out3_valid, bus.out2_valid, bus.out1_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("rst_data", {16'd0, bus.out1_data}, 32'd0);
`ifdef DEMUX_STATS_EN
    chk("rst_xfer_count", {16'd0, xfer_count}, 32'd0);
`endif
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: single route to out1, idle one cycle later.
    send(16'h0001, 2'b00);
    chk("t1_valids", {29'd0, bus.out3_valid, bus.out2_valid, bus.out1_valid}, 32'b001);
    chk("t1_data", {16'd0, bus.out1_data}, 32'h0001);
    @(posedge clk); #1;
    chk("t1_idle", {29'd0, bus.out3_valid, bus.out2_valid, bus.out1_valid}, 32'd0);

    // 2: out2 stalled for 3 cycles.
    set_ready(3'b101);
    send(16'h0002, 2'b01);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t2_hold_valid", {31'd0, bus.out2_valid}, 32'd1);
      chk("t2_hold_in_ready", {31'd0, bus.in_ready}, 32'd0);
      if (i < 2) @(posedge clk);
    end
    set_ready(3'b111);
    #1;
    chk("t2_drain_in_ready", {31'd0, bus.in_ready}, 32'd1);
    @(posedge clk); #1;
    chk("t2_idle", {31'd0, bus.out2_valid}, 32'd0);

    // 3: broadcast, staggered drain out1, out3, (gap), out2.
    set_ready(3'b000);
    send(16'h0004, 2'b11);
    set_ready(3'b001);
    #1 chk("t3_c1_in_ready", {31'd0, bus.in_ready}, 32'd0);
    @(posedge clk); #1;
    set_ready(3'b100);
    chk("t3_c2_valids", {29'd0, bus.out3_valid, bus.out2_valid, bus.out1_valid}, 32'b110);
    chk("t3_c2_in_ready", {31'd0, bus.in_ready}, 32'd0);
    @(posedge clk); #1;
    set_ready(3'b000);
    chk("t3_c3_valids", {29'd0, bus.out3_valid, bus.out2_valid, bus.out1_valid}, 32'b010);
    chk("t3_c3_in_ready", {31'd0, bus.in_ready}, 32'd0);
    @(posedge clk); #1;
    set_ready(3'b010);
    #1 chk("t3_c4_in_ready", {31'd0, bus.in_ready}, 32'd1);
    @(posedge clk); #1;
    chk("t3_idle", {29'd0, bus.out3_valid, bus.out2_valid, bus.out1_valid}, 32'd0);

    // 4: back-to-back accepts, sel cycling.
    set_ready(3'b111);
    c0 = cycle;
    for (int i = 0; i < 8; i++) send(16'h0100 + 16'(i), 2'(i));
    chk("t4_throughput", cycle - c0, 32'd8);
    @(posedge clk); #1;

    // 5: asynchronous reset with broadcast partly drained.
    set_ready(3'b101);
    send(16'h0055, 2'b11);
    @(posedge clk); #1;
    chk("t5_pre_valids", {29'd0, bus.out3_valid, bus.out2_valid, bus.out1_valid}, 32'b010);
    #1 rst_n = 1'b0;
    #1;
    chk("t5_rst_valids", {29'd0, bus.out3_valid, bus.out2_valid, bus.out1_valid}, 32'd0);
    chk("t5_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("t5_rst_data", {16'd0, bus.out2_data}, 32'd0);
    q1.delete();
    q2.delete();
    q3.delete();
    @(negedge clk);
    rst_n = 1'b1;
    set_ready(3'b111);
    @(posedge clk); #1;

`ifdef DEMUX_STATS_EN
    // 6: counter wraps after 65537 accepts.
    chk("t6_count_start", {16'd0, xfer_count}, 32'd0);
    for (int i = 0; i < 65537; i++) send(16'(i), 2'b00);
    chk("t6_count_wrap", {16'd0, xfer_count}, 32'd1);
`endif

    repeat (3) @(posedge clk);
    #1;
    chk("end_q1_empty", q1.size(), 32'd0);
    chk("end_q2_empty", q2.size(), 32'd0);
    chk("end_q3_empty", q3.size(), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
